// File: rtl/z80_clk_sequencer.sv
// Sequences the Z80 clock divider: power-on CPU reset, free-run, stop and N-cycle step.
// Divider strobes, CPU reset and status outputs are all registered.
module z80_clk_sequencer #(
  parameter int unsigned POR_CYCLES = 8,
  parameter int unsigned STEP_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_run_stb,
  input  logic                  i_stop_stb,
  input  logic                  i_step_stb,
  input  logic [STEP_WIDTH-1:0] i_step_count,
  input  logic                  i_cpu_reset_stb,
  input  logic                  i_div_clk_rose,
  output logic                  o_div_start_stb,
  output logic                  o_div_reset_stb,
  output logic                  o_cpu_reset_n,
  output logic                  o_busy,
  output logic                  o_done_stb,
  output logic [STEP_WIDTH-1:0] o_step_remaining,
  output logic [1:0]            o_state
);

  localparam int unsigned POR_W = $clog2(POR_CYCLES + 1);

  typedef enum logic [1:0] {
    S_POR_START = 2'd0,
    S_IDLE      = 2'd1,
    S_RUN       = 2'd2,
    S_STEP      = 2'd3
  } state_t;

  state_t                r_state, w_state;
  logic                  r_por_started, w_por_started;
  logic [POR_W-1:0]      r_por_cnt, w_por_cnt;
  logic                  r_start_stb, w_start_stb;
  logic                  r_reset_stb, w_reset_stb;
  logic                  r_cpu_reset_n, w_cpu_reset_n;
  logic                  r_busy, w_busy;
  logic                  r_done_stb, w_done_stb;
  logic [STEP_WIDTH-1:0] r_step_rem, w_step_rem;
  logic [STEP_WIDTH-1:0] w_rem_dec;

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_POR_START;
      r_por_started <= 1'b0;
      r_por_cnt     <= '0;
      r_start_stb   <= 1'b0;
      r_reset_stb   <= 1'b0;
      r_cpu_reset_n <= 1'b0;
      r_busy        <= 1'b1;
      r_done_stb    <= 1'b0;
      r_step_rem    <= '0;
    end else begin
      r_state       <= w_state;
      r_por_started <= w_por_started;
      r_por_cnt     <= w_por_cnt;
      r_start_stb   <= w_start_stb;
      r_reset_stb   <= w_reset_stb;
      r_cpu_reset_n <= w_cpu_reset_n;
      r_busy        <= w_busy;
      r_done_stb    <= w_done_stb;
      r_step_rem    <= w_step_rem;
    end
  end

  // Next-state and next-output logic; strobes default low so they last one cycle
  always_comb begin
    w_state       = r_state;
    w_por_started = r_por_started;
    w_por_cnt     = r_por_cnt;
    w_start_stb   = 1'b0;
    w_reset_stb   = 1'b0;
    w_cpu_reset_n = r_cpu_reset_n;
    w_busy        = r_busy;
    w_done_stb    = 1'b0;
    w_step_rem    = r_step_rem;
    w_rem_dec     = r_step_rem - STEP_WIDTH'(1);

    case (r_state)
      S_POR_START: begin
        if (!r_por_started) begin
          w_start_stb   = 1'b1;
          w_por_cnt     = POR_W'(POR_CYCLES);
          w_por_started = 1'b1;
        end else if (i_div_clk_rose) begin
          w_por_cnt = r_por_cnt - POR_W'(1);
          if (r_por_cnt == POR_W'(1)) begin
            w_cpu_reset_n = 1'b1;
            w_reset_stb   = 1'b1;
            w_busy        = 1'b0;
            w_state       = S_IDLE;
          end
        end
      end

      S_IDLE: begin
        if (i_run_stb) begin
          w_state     = S_RUN;
          w_start_stb = 1'b1;
          w_busy      = 1'b1;
        end else if (i_step_stb) begin
          if (i_step_count != '0) begin
            w_step_rem  = i_step_count;
            w_state     = S_STEP;
            w_start_stb = 1'b1;
            w_busy      = 1'b1;
          end else begin
            w_done_stb = 1'b1;
          end
        end else if (i_cpu_reset_stb) begin
          w_cpu_reset_n = 1'b0;
          w_state       = S_POR_START;
          w_por_started = 1'b0;
          w_busy        = 1'b1;
        end
      end

      S_RUN: begin
        if (i_stop_stb) begin
          w_reset_stb = 1'b1;
          w_done_stb  = 1'b1;
          w_busy      = 1'b0;
          w_state     = S_IDLE;
        end else if (i_cpu_reset_stb) begin
          w_cpu_reset_n = 1'b0;
          w_state       = S_POR_START;
          w_por_started = 1'b0;
          w_busy        = 1'b1;
        end
      end

      S_STEP: begin
        // A rose coinciding with stop is still counted before the abort
        if (i_div_clk_rose) begin
          w_step_rem = w_rem_dec;
        end
        if (i_stop_stb || (i_div_clk_rose && r_step_rem == STEP_WIDTH'(1))) begin
          w_reset_stb = 1'b1;
          w_done_stb  = 1'b1;
          w_busy      = 1'b0;
          w_state     = S_IDLE;
        end else if (i_cpu_reset_stb) begin
          w_cpu_reset_n = 1'b0;
          w_state       = S_POR_START;
          w_por_started = 1'b0;
          w_busy        = 1'b1;
        end
      end

      default: begin
        w_state = S_POR_START;
      end
    endcase
  end

  assign o_div_start_stb  = r_start_stb;
  assign o_div_reset_stb  = r_reset_stb;
  assign o_cpu_reset_n    = r_cpu_reset_n;
  assign o_busy           = r_busy;
  assign o_done_stb       = r_done_stb;
  assign o_step_remaining = r_step_rem;
  assign o_state          = r_state;

endmodule

// File: tb/tb_z80_clk_sequencer.sv
// Bench for z80_clk_sequencer: directed plan steps plus random command traffic,
// every cycle compared against a command-level reference model.
module tb_z80_clk_sequencer;

  localparam int unsigned POR_CYCLES = 8;
  localparam int unsigned STEP_WIDTH = 16;

  logic                  i_clk = 1'b0;
  logic                  i_reset_n;
  logic                  i_run_stb;
  logic                  i_stop_stb;
  logic                  i_step_stb;
  logic [STEP_WIDTH-1:0] i_step_count;
  logic                  i_cpu_reset_stb;
  logic                  i_div_clk_rose;
  logic                  o_div_start_stb;
  logic                  o_div_reset_stb;
  logic                  o_cpu_reset_n;
  logic                  o_busy;
  logic                  o_done_stb;
  logic [STEP_WIDTH-1:0] o_step_remaining;
  logic [1:0]            o_state;

  z80_clk_sequencer #(.POR_CYCLES(POR_CYCLES), .STEP_WIDTH(STEP_WIDTH)) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_run_stb       (i_run_stb),
    .i_stop_stb      (i_stop_stb),
    .i_step_stb      (i_step_stb),
    .i_step_count    (i_step_count),
    .i_cpu_reset_stb (i_cpu_reset_stb),
    .i_div_clk_rose  (i_div_clk_rose),
    .o_div_start_stb (o_div_start_stb),
    .o_div_reset_stb (o_div_reset_stb),
    .o_cpu_reset_n   (o_cpu_reset_n),
    .o_busy          (o_busy),
    .o_done_stb      (o_done_stb),
    .o_step_remaining(o_step_remaining),
    .o_state         (o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0=power-on reset, 1=idle, 2=running, 3=stepping
  int m_mode;
  bit m_clock_started;
  int m_roses_seen;
  int m_rem;
  bit e_start, e_rst, e_cpu_n, e_busy, e_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_clock_started = 0; m_roses_seen = 0; m_rem = 0;
    e_start = 0; e_rst = 0; e_cpu_n = 0; e_busy = 1; e_done = 0;
  endtask

  task automatic model_cpu_reset();
    e_cpu_n = 0; e_busy = 1; m_mode = 0; m_clock_started = 0;
  endtask

  task automatic model_finish_run();
    e_rst = 1; e_done = 1; e_busy = 0; m_mode = 1;
  endtask

  // Applies the command rules to the inputs present at this clock edge
  task automatic model_edge();
    e_start = 0; e_rst = 0; e_done = 0;
    if (m_mode == 0) begin
      if (!m_clock_started) begin
        e_start = 1; m_clock_started = 1; m_roses_seen = 0;
      end else if (i_div_clk_rose) begin
        m_roses_seen++;
        if (m_roses_seen == POR_CYCLES) begin
          e_cpu_n = 1; e_rst = 1; e_busy = 0; m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (i_run_stb) begin
        m_mode = 2; e_start = 1; e_busy = 1;
      end else if (i_step_stb) begin
        if (i_step_count != 0) begin
          m_rem = int'(i_step_count); m_mode = 3; e_start = 1; e_busy = 1;
        end else e_done = 1;
      end else if (i_cpu_reset_stb) model_cpu_reset();
    end else if (m_mode == 2) begin
      if (i_stop_stb) model_finish_run();
      else if (i_cpu_reset_stb) model_cpu_reset();
    end else begin
      if (i_div_clk_rose) m_rem--;
      if (i_stop_stb || m_rem == 0) model_finish_run();
      else if (i_cpu_reset_stb) model_cpu_reset();
    end
  endtask

  task automatic check_all();
    check("state", 32'(o_state), 32'(m_mode));
    check("start_stb", 32'(o_div_start_stb), 32'(e_start));
    check("reset_stb", 32'(o_div_reset_stb), 32'(e_rst));
    check("cpu_reset_n", 32'(o_cpu_reset_n), 32'(e_cpu_n));
    check("busy", 32'(o_busy), 32'(e_busy));
    check("done_stb", 32'(o_done_stb), 32'(e_done));
    check("remaining", 32'(o_step_remaining), 32'(m_rem));
  endtask

  task automatic clear_inputs();
    i_run_stb = 0; i_stop_stb = 0; i_step_stb = 0; i_cpu_reset_stb = 0; i_div_clk_rose = 0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
    check_all();
    clear_inputs();
  endtask

  task automatic roses(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      for (int g = 1; g < gap; g++) tick();
      i_div_clk_rose = 1;
      tick();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(o_state), 32'd0);
    check({tag, "_start"}, 32'(o_div_start_stb), 32'd0);
    check({tag, "_rst"}, 32'(o_div_reset_stb), 32'd0);
    check({tag, "_cpu_n"}, 32'(o_cpu_reset_n), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
    check({tag, "_done"}, 32'(o_done_stb), 32'd0);
    check({tag, "_rem"}, 32'(o_step_remaining), 32'd0);
  endtask

  initial begin
    clear_inputs();
    i_step_count = '0;
    i_reset_n = 0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1 check_reset_values("por_held");
    @(negedge i_clk) i_reset_n = 1;

    // Power-on: start strobe at first edge, release after 8 roses spaced 20 cycles
    tick();
    check("por_start_stb", 32'(o_div_start_stb), 32'd1);
    roses(POR_CYCLES, 20);
    check("por_release_rst", 32'(o_div_reset_stb), 32'd1);
    tick();
    check("por_idle_state", 32'(o_state), 32'd1);
    check("por_idle_busy", 32'(o_busy), 32'd0);

    // Step 3
    i_step_count = 16'd3; i_step_stb = 1; tick();
    check("step3_rem", 32'(o_step_remaining), 32'd3);
    roses(3, 4);
    check("step3_done", 32'({o_div_reset_stb, o_done_stb}), 32'd3);
    tick();
    check("step3_idle", 32'(o_state), 32'd1);

    // Free-run across 50 roses, then stop
    i_run_stb = 1; tick();
    roses(50, 2);
    i_stop_stb = 1; tick();
    check("run_stop_done", 32'({o_div_reset_stb, o_done_stb, o_busy}), 32'b110);

    // Step 10 aborted after 4 roses
    i_step_count = 16'd10; i_step_stb = 1; tick();
    roses(4, 3);
    i_stop_stb = 1; tick();
    check("abort_rem", 32'(o_step_remaining), 32'd6);

    // Zero-count step
    i_step_count = 16'd0; i_step_stb = 1; tick();
    check("step0_done", 32'({o_done_stb, o_div_start_stb, o_div_reset_stb}), 32'b100);

    // CPU reset from RUN, run strobe ignored during POR
    i_run_stb = 1; tick();
    roses(2, 2);
    i_cpu_reset_stb = 1; tick();
    check("cpurst_low", 32'(o_cpu_reset_n), 32'd0);
    i_run_stb = 1; tick();
    roses(POR_CYCLES, 3);
    tick();
    check("cpurst_idle", 32'(o_state), 32'd1);

    // Random command traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 7))
        0: i_run_stb = 1;
        1: i_stop_stb = 1;
        2: begin i_step_count = STEP_WIDTH'($urandom_range(0, 9)); i_step_stb = 1; end
        3: if ($urandom_range(0, 3) == 0) i_cpu_reset_stb = 1;
        4: begin i_stop_stb = 1; i_cpu_reset_stb = 1; end
        5: begin i_stop_stb = 1; i_div_clk_rose = 1; end
        default: roses(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)));
      endcase
      tick();
    end

    // Async reset mid-step with 5 remaining
    roses(POR_CYCLES + 1, 1);
    tick();
    if (o_state != 2'd1) begin
      i_stop_stb = 1; tick();
    end
    i_step_count = 16'd8; i_step_stb = 1; tick();
    roses(3, 2);
    check("pre_async_rem", 32'(o_step_remaining), 32'd5);
    #2 i_reset_n = 0;
    model_reset();
    #1 check_reset_values("async");
    @(negedge i_clk) i_reset_n = 1;
    tick();
    check("repor_start", 32'(o_div_start_stb), 32'd1);
    roses(POR_CYCLES, 5);
    tick();
    check("repor_idle", 32'({o_state, o_cpu_reset_n}), 32'b011);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/z80_clk_sequencer.md
Name: z80_clk_sequencer

Overview:
- Controller that sequences the system clock divider driving the Z80's CLK pin.
- Starts and stops the divider through its start/reset strobes and counts its rising-edge indications.
- Provides power-on CPU reset (held for a fixed number of CPU clocks), free-run, stop and N-cycle single-step modes.
- Sits between the debug/UART command decoder and the clock divider instance; its outputs also drive the Z80 RESET pin and status LEDs.

Parameters:
- POR_CYCLES, 8, number of divided-clock rising edges the CPU reset is held low (must be >= 1).
- STEP_WIDTH, 16, width of step count input and remaining-count output.

Ports:
- i_clk  input  1  system clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_run_stb  input  1  one-cycle strobe: start free-running CPU clock.
- i_stop_stb  input  1  one-cycle strobe: stop CPU clock.
- i_step_stb  input  1  one-cycle strobe: run i_step_count CPU clocks, then stop.
- i_step_count  input  STEP_WIDTH  cycle count, sampled only on i_step_stb.
- i_cpu_reset_stb  input  1  one-cycle strobe: re-run CPU reset sequence.
- i_div_clk_rose  input  1  divider's one-cycle indication of divided-clock rising edge.
- o_div_start_stb  output  1  to divider start strobe.
- o_div_reset_stb  output  1  to divider reset strobe.
- o_cpu_reset_n  output  1  Z80 RESET, active low.
- o_busy  output  1  high in any state but IDLE.
- o_done_stb  output  1  one-cycle pulse when a run/step ends and the clock is stopped.
- o_step_remaining  output  STEP_WIDTH  CPU clocks left in current/aborted step.
- o_state  output  2  current state encoding, for debug LEDs.

Behaviour:
- Reset is asynchronous, active-low, on one clock i_clk. All outputs are registered.
- Reset values: state=POR_START (2'd0), o_div_start_stb=0, o_div_reset_stb=0, o_cpu_reset_n=0, o_busy=1, o_done_stb=0, o_step_remaining=0.
- Internal counter por_cnt has width clog2(POR_CYCLES+1).
- States and encodings: POR_START=0, IDLE=1, RUN=2, STEP=3. POR_WAIT is folded into POR_START via the flag por_started.
- POR_START:
  - On the first edge after reset release: o_div_start_stb=1 for exactly one cycle; por_cnt<=POR_CYCLES; por_started<=1.
  - Afterwards, each i_div_clk_rose decrements por_cnt.
  - On i_div_clk_rose with por_cnt==1: o_cpu_reset_n<=1, o_div_reset_stb<=1 (one cycle), o_busy<=0, state<=IDLE.
  - All command strobes are ignored in this state.
- IDLE, with priority run > step > cpu_reset:
  - i_run_stb: state<=RUN, o_div_start_stb=1 one cycle, o_busy<=1.
  - i_step_stb with count!=0: o_step_remaining<=i_step_count, state<=STEP, o_div_start_stb pulse, o_busy<=1.
  - i_step_stb with count==0: o_done_stb pulses next cycle, stay IDLE, no divider strobe.
  - i_stop_stb: ignored.
- RUN:
  - i_stop_stb: o_div_reset_stb and o_done_stb pulse together, state<=IDLE, o_busy<=0.
  - i_run_stb and i_step_stb: ignored.
- STEP:
  - Each i_div_clk_rose decrements o_step_remaining.
  - On rose with remaining==1: remaining<=0, reset_stb + done_stb pulse, state<=IDLE.
  - i_stop_stb aborts with the same strobes; remaining keeps its value (minus 1 if a rose coincides).
  - Run/step strobes ignored.
- i_cpu_reset_stb, in IDLE/RUN/STEP (stop has priority if simultaneous in RUN/STEP):
  - o_cpu_reset_n<=0, state<=POR_START, por_started<=0, o_busy<=1, no done_stb.
  - The sequence then re-issues start_stb; this is harmless if the divider is already counting.
- o_div_start_stb and o_div_reset_stb are never asserted in the same cycle.
- All strobes are exactly one cycle wide.
- Async reset mid-operation returns to reset values immediately. The divider itself is reset by the shared i_reset_n.

Test Plan:
- Reset release, POR_CYCLES=8, bench pulses i_div_clk_rose every 20 cycles -> start_stb at cycle 1; o_cpu_reset_n rises and reset_stb pulses on the cycle after the 8th rose; o_state=1, o_busy=0.
- In IDLE, i_step_stb with i_step_count=3 -> start_stb pulse; remaining 3→2→1→0 on each rose; after the 3rd rose, reset_stb and done_stb pulse together, o_state=1.
- i_run_stb, 50 rose pulses, then i_stop_stb -> one start_stb, no done until stop; then reset_stb+done_stb next cycle, o_busy=0.
- Step count=10, stop after 4 roses -> abort strobes; o_step_remaining=6. Step with count=0 -> done_stb only, no divider strobes.
- In RUN, assert i_cpu_reset_stb -> o_cpu_reset_n=0 next cycle, start_stb pulse, 8 roses later reset released. i_run_stb during POR is ignored.
- Async reset asserted mid-STEP (remaining=5) -> all outputs return to reset values without waiting for i_clk; after release, the POR sequence repeats.
